// File: rtl/word_count_accum.sv
// word_count_accum
//   Per-entry {value, count} accumulation table for the word-count datapath.
//   Merges the search-and-add write stream (one write per counted word, keyed
//   by entry address) into a RAM table. On command it either invalidates the
//   whole table (CLEAR) or streams every valid entry out in ascending address
//   order (DUMP) through a ready/valid port.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   accum_addr/din/we     write stream: index, {value, increment}, strobe
//   clear_kick, dump_kick requests, accepted only while idle
//   busy                  CLEAR/DUMP in progress or a kick pending
//   dout/dout_valid/ready readout beat {index16, value32, count32}
//   dump_done             one-cycle pulse at the end of a dump
//   num_entries           number of valid entries
//   err                   sticky dropped-write flag
module word_count_accum #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       accum_addr,
   input  logic [63:0]       accum_din,
   input  logic              accum_we,
   input  logic              clear_kick,
   input  logic              dump_kick,
   output logic              busy,
   output logic [79:0]       dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dump_done,
   output logic [ADDR_W:0]   num_entries,
   output logic              err
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic        v;
      logic [31:0] value;
      logic [31:0] count;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DUMP} state_t;

   state_t             state;
   entry_t             mem [DEPTH];
   entry_t             rd_q;

   // write pipeline: s1 = merge stage, s2 = RAM write stage,
   // s3 = copy of the entry written last edge (not yet visible in rd_q)
   logic               s1_v, s2_v, s3_v, s2_new;
   logic [ADDR_W-1:0]  s1_addr, s2_addr, s3_addr;
   logic [63:0]        s1_din;
   entry_t             s2_ent, s3_ent;

   logic               pend, pend_clr;
   logic [ADDR_W-1:0]  clr_idx;
   logic [ADDR_W:0]    scan_cnt;   // MSB set once every index has been issued
   logic               rd_v;       // rd_q holds a dump read
   logic [ADDR_W-1:0]  rd_idx;

   logic               wr_ok, out_free, rd_take, scan_issue, load;
   logic               rd_en, mem_we;
   logic [ADDR_W-1:0]  rd_addr, mem_waddr;
   entry_t             mem_wdata, base, merged;
   logic               merged_new;
   logic [32:0]        sum;

   // New writes are refused once a kick is pending so the pipeline drains.
   assign wr_ok = accum_we && (state == S_IDLE) && !pend &&
                  (accum_addr[31:ADDR_W] == '0);

   // Dump read stage: invalid entries are dropped at once, valid ones wait
   // for the output register to free up.
   assign out_free   = !dout_valid || dout_ready;
   assign rd_take    = rd_v && (!rd_q.v || out_free);
   assign scan_issue = (state == S_DUMP) && !scan_cnt[ADDR_W] && (!rd_v || rd_take);
   assign load       = rd_take && rd_q.v;

   assign rd_en     = wr_ok || scan_issue;
   assign rd_addr   = (state == S_DUMP) ? scan_cnt[ADDR_W-1:0] : accum_addr[ADDR_W-1:0];
   assign mem_we    = (state == S_CLEAR) || s2_v;
   assign mem_waddr = (state == S_CLEAR) ? clr_idx : s2_addr;
   assign mem_wdata = (state == S_CLEAR) ? '0 : s2_ent;

   assign busy = (state != S_IDLE) || pend;

   always_ff @(posedge clk) begin
      if (rd_en)  rd_q <= mem[rd_addr];
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Merge with forwarding; the younger in-flight copy wins.
   always_comb begin
      base = rd_q;
      if (s3_v && (s3_addr == s1_addr)) base = s3_ent;
      if (s2_v && (s2_addr == s1_addr)) base = s2_ent;
      sum        = {1'b0, base.count} + {1'b0, s1_din[31:0]};
      merged_new = !base.v;
      merged.v   = 1'b1;
      if (!base.v) begin
         merged.value = s1_din[63:32];
         merged.count = s1_din[31:0];
      end else begin
         merged.value = base.value;
         merged.count = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_CLEAR;
         s1_v        <= 1'b0;
         s1_addr     <= '0;
         s1_din      <= '0;
         s2_v        <= 1'b0;
         s2_new      <= 1'b0;
         s2_addr     <= '0;
         s2_ent      <= '0;
         s3_v        <= 1'b0;
         s3_addr     <= '0;
         s3_ent      <= '0;
         pend        <= 1'b0;
         pend_clr    <= 1'b0;
         clr_idx     <= '0;
         scan_cnt    <= '0;
         rd_v        <= 1'b0;
         rd_idx      <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         dump_done   <= 1'b0;
         num_entries <= '0;
         err         <= 1'b0;
      end else begin
         s1_v    <= wr_ok;
         s1_addr <= accum_addr[ADDR_W-1:0];
         s1_din  <= accum_din;
         s2_v    <= s1_v;
         s2_addr <= s1_addr;
         s2_ent  <= merged;
         s2_new  <= merged_new;
         s3_v    <= s2_v;
         s3_addr <= s2_addr;
         s3_ent  <= s2_ent;
         if (s2_v && s2_new) num_entries <= num_entries + 1'b1;
         if (accum_we && !wr_ok) err <= 1'b1;
         dump_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (!pend) begin
                  if (clear_kick) begin
                     pend     <= 1'b1;
                     pend_clr <= 1'b1;
                  end else if (dump_kick) begin
                     pend     <= 1'b1;
                     pend_clr <= 1'b0;
                  end
               end else if (!s1_v) begin
                  // s2 (if any) is written on this same edge
                  pend <= 1'b0;
                  if (pend_clr) begin
                     state       <= S_CLEAR;
                     clr_idx     <= '0;
                     num_entries <= '0;
                     err         <= 1'b0;
                  end else begin
                     state    <= S_DUMP;
                     scan_cnt <= '0;
                     rd_v     <= 1'b0;
                  end
               end
            end
            S_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (&clr_idx) state <= S_IDLE;
            end
            S_DUMP: begin
               if (scan_issue) begin
                  rd_v     <= 1'b1;
                  rd_idx   <= scan_cnt[ADDR_W-1:0];
                  scan_cnt <= scan_cnt + 1'b1;
               end else if (rd_take) begin
                  rd_v <= 1'b0;
               end
               if (load) begin
                  dout_valid <= 1'b1;
                  dout       <= {16'(rd_idx), rd_q.value, rd_q.count};
               end else if (dout_valid && dout_ready) begin
                  dout_valid <= 1'b0;
               end
               // pulse first, drop busy the cycle after
               if (dump_done)
                  state <= S_IDLE;
               else if (scan_cnt[ADDR_W] && !rd_v && !dout_valid)
                  dump_done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
